dec_pulse_gen: RTL and testbench
================================

Name: dec_pulse_gen

Overview:
Binary-to-one-hot pulse decoder, the inverse of the team's one-hot-to-binary encoder. It accepts a binary line index through a valid/ready handshake. It then drives exactly one bit of a one-hot output bus for a programmable number of cycles, followed by a fixed idle gap. It sits between a control sequencer and per-line strobe consumers such as mux selects and channel enables.

Parameters:
IN_SIZE, 2, width of the binary index input
OUT_SIZE, 1<<IN_SIZE, number of one-hot output lines
LEN_W, 4, width of the pulse-length input
GAP, 1, number of forced all-zero cycles after each pulse (0 allowed)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in  input  IN_SIZE  binary line index
len  input  LEN_W  pulse length in cycles; 0 is treated as 1
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid && in_ready at the clock edge
enable  input  1  global enable; low aborts the current operation
out  output  OUT_SIZE  one-hot strobe bus; all zero when not pulsing
busy  output  1  high in ACTIVE or GAP state
done  output  1  one-cycle pulse on the final ACTIVE cycle of a pulse

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - state=IDLE; out=0, busy=0, done=0, in_ready=0.
  - Length counter and gap counter = 0; captured index = 0.
- All outputs are registered, except in_ready, which is combinational from state and enable.
- States: IDLE, ACTIVE, GAP.
- IDLE:
  - in_ready = enable.
  - On handshake at edge N: capture in and L = max(len,1); load the counter with L-1; go to ACTIVE.
  - out[in] = 1 from cycle N+1. Latency is exactly one cycle.
- ACTIVE:
  - out = 1 << captured index, with only that bit set.
  - The counter decrements each cycle.
  - When the counter is 0 (last cycle): done = 1 in that same cycle. Next state is GAP if GAP > 0, otherwise IDLE.
  - The pulse lasts exactly L cycles.
- GAP:
  - out = 0 for exactly GAP cycles, then IDLE.
  - in_ready = 0.
- Width rules:
  - Index is always in range because OUT_SIZE = 1<<IN_SIZE.
  - Counters are LEN_W bits, plus $clog2(GAP+1) bits for the gap counter. No wrap-around is possible.
  - len = 2^LEN_W - 1 gives the maximum pulse of 15 cycles at the default width.
- enable deasserted in ACTIVE or GAP:
  - Next edge: state IDLE, out=0, done=0, busy=0. The aborted pulse never raises done.
  - A pending command (see optional feature) is discarded.
- enable low in IDLE: in_ready=0; no command is accepted.
- rst asserted mid-pulse: out clears immediately (asynchronously); all state returns to reset values.
- in and len are sampled only at the handshake. Changes while busy have no effect.
- Invariant: $onehot0(out) holds every cycle.

Optional Feature:
Macro DEC_PULSE_QUEUE_EN.
- Defined:
  - Adds a one-entry pending register (index and len).
  - in_ready = enable && !pending_valid in every state, so commands are accepted while ACTIVE or GAP.
  - After the GAP of the current pulse ends, or after the last ACTIVE cycle if GAP=0, a pending command moves directly to ACTIVE with no IDLE cycle.
  - A handshake in IDLE behaves as without the macro.
  - Simultaneous handshake and pending-drain in the same cycle: the drain takes place and the new command fills the pending slot.
- Not defined:
  - in_ready is high only in IDLE, no pending storage exists, and at least one IDLE cycle separates pulses.

Test Plan:
1. Reset then idle, enable=1, in_valid=0 for 10 cycles -> out=0, busy=0, done=0, in_ready=1 throughout.
2. Handshake in=2, len=3 at edge N -> out=4'b0100 in cycles N+1..N+3, done=1 only in N+3, out=0 in N+4 (GAP=1), in_ready=1 again from N+5.
3. Each index 0..3 with len=0 -> single-cycle pulse: out equals 1,2,4,8 respectively, done coincident; len=0 behaves identically to len=1.
4. in=3, len=15, deassert enable on the 5th ACTIVE cycle -> out=0 from the next edge, done never asserted, state IDLE; re-enable and in=1, len=1 -> out=4'b0010 for one cycle.
5. Assert rst mid-pulse (in=1, len=8, 3rd cycle) asynchronously between edges -> out=0 before the next clock edge; all outputs at reset values after release.
6. DEC_PULSE_QUEUE_EN defined, GAP=1: in=0, len=2, then in=3, len=1 accepted during ACTIVE -> out=0001 for two cycles, 0000 for one, then 1000 for one cycle; a third command is refused (in_ready=0) while pending is full.

Source files
------------

// File: rtl/dec_pulse_gen.sv
// Binary-to-one-hot pulse decoder: one line strobed for a programmable length, then a fixed idle gap.
// Optional one-entry command queue enabled by defining DEC_PULSE_QUEUE_EN.
module dec_pulse_gen #(
   parameter int IN_SIZE  = 2,
   parameter int OUT_SIZE = 1 << IN_SIZE,
   parameter int LEN_W    = 4,
   parameter int GAP      = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IN_SIZE-1:0]  in,
   input  logic [LEN_W-1:0]    len,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                enable,
   output logic [OUT_SIZE-1:0] out,
   output logic                busy,
   output logic                done
);

   localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

   state_t              r_state;
   logic [LEN_W-1:0]    r_cnt;
   logic [GAP_W-1:0]    r_gcnt;
   logic [OUT_SIZE-1:0] r_out;
   logic                r_busy;
   logic                r_done;

   logic                w_hs;
   logic [LEN_W-1:0]    w_len;
   logic                w_pulse_end;
   logic                w_launch;
   logic [IN_SIZE-1:0]  w_lidx;
   logic [LEN_W-1:0]    w_llen;

   assign w_hs  = in_valid && in_ready;
   assign w_len = (len == '0) ? LEN_W'(1) : len;

   // Point at which the next pulse may start without passing through IDLE
   assign w_pulse_end = ((r_state == S_ACTIVE) && (r_cnt == '0) && (GAP == 0)) ||
                        ((r_state == S_GAP) && (r_gcnt == '0));

`ifdef DEC_PULSE_QUEUE_EN
   logic                r_pvld;
   logic [IN_SIZE-1:0]  r_pidx;
   logic [LEN_W-1:0]    r_plen;
   logic                w_fill;

   assign in_ready = !rst && enable && !r_pvld;
   assign w_launch = ((r_state == S_IDLE) && w_hs) || (w_pulse_end && (r_pvld || w_hs));
   assign w_lidx   = r_pvld ? r_pidx : in;
   assign w_llen   = r_pvld ? r_plen : w_len;
   assign w_fill   = w_hs && (r_state != S_IDLE) && !w_pulse_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pvld <= 1'b0;
         r_pidx <= '0;
         r_plen <= '0;
      end else if (!enable) begin
         r_pvld <= 1'b0;
      end else if (w_fill) begin
         r_pvld <= 1'b1;
         r_pidx <= in;
         r_plen <= w_len;
      end else if (w_launch && r_pvld) begin
         r_pvld <= 1'b0;
      end
   end
`else
   assign in_ready = !rst && enable && (r_state == S_IDLE);
   assign w_launch = (r_state == S_IDLE) && w_hs;
   assign w_lidx   = in;
   assign w_llen   = w_len;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_gcnt  <= '0;
         r_out   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (!enable) begin
         r_state <= S_IDLE;
         r_out   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (w_launch) begin
         r_state <= S_ACTIVE;
         r_out   <= OUT_SIZE'(1) << w_lidx;
         r_cnt   <= w_llen - LEN_W'(1);
         r_done  <= (w_llen == LEN_W'(1));
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_out  <= '0;
               r_busy <= 1'b0;
               r_done <= 1'b0;
            end
            S_ACTIVE: begin
               // done is raised one edge early so it lands on the final ACTIVE cycle
               if (r_cnt != '0) begin
                  r_cnt  <= r_cnt - LEN_W'(1);
                  r_done <= (r_cnt == LEN_W'(1));
               end else if (GAP > 0) begin
                  r_state <= S_GAP;
                  r_out   <= '0;
                  r_done  <= 1'b0;
                  r_gcnt  <= GAP_W'(GAP - 1);
               end else begin
                  r_state <= S_IDLE;
                  r_out   <= '0;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            S_GAP: begin
               if (r_gcnt != '0) begin
                  r_gcnt <= r_gcnt - GAP_W'(1);
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_out   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign out  = r_out;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_dec_pulse_gen.sv
// Directed self-checking bench for dec_pulse_gen (default parameters).
// Queue scenario is included only when DEC_PULSE_QUEUE_EN is defined.
module tb_dec_pulse_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] in;
   logic [3:0] len;
   logic       in_valid;
   logic       in_ready;
   logic       enable;
   logic [3:0] out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

`ifdef DEC_PULSE_QUEUE_EN
   localparam logic Q = 1'b1;
`else
   localparam logic Q = 1'b0;
`endif

   typedef struct {
      logic       en;
      logic       vld;
      logic [1:0] in;
      logic [3:0] len;
      logic [3:0] eo;
      logic       eb;
      logic       ed;
      logic       er;
   } vec_t;

   vec_t tbl[$];

   dec_pulse_gen #(.IN_SIZE(2), .OUT_SIZE(4), .LEN_W(4), .GAP(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in),
      .len      (len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .enable   (enable),
      .out      (out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] eo, input logic eb,
                      input logic ed, input logic er);
      logic [6:0] act;
      logic [6:0] exp;
      act = {out, busy, done, in_ready};
      exp = {eo, eb, ed, er};
      checks++;
      if (act !== exp || !$onehot0(out)) begin
         errors++;
         $display("FAIL %s at %0t: {out,busy,done,in_ready} got %b_%b%b%b expected %b_%b%b%b",
                  name, $time, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic add(input logic en, input logic vld, input logic [1:0] i, input logic [3:0] l,
                      input logic [3:0] eo, input logic eb, input logic ed, input logic er);
      vec_t v;
      v.en = en; v.vld = vld; v.in = i; v.len = l;
      v.eo = eo; v.eb = eb; v.ed = ed; v.er = er;
      tbl.push_back(v);
   endtask

   initial begin
      // Pulse in=2 len=3, with in/len wiggled while busy
      add(1, 1, 2, 3, 4'b0000, 0, 0, 1);
      add(1, 0, 1, 7, 4'b0100, 1, 0, Q);
      add(1, 0, 0, 0, 4'b0100, 1, 0, Q);
      add(1, 0, 3, 9, 4'b0100, 1, 1, Q);
      add(1, 0, 0, 0, 4'b0000, 1, 0, Q);
      // Single-cycle pulses on every line; len 0 and len 1 alternate
      for (int i = 0; i < 4; i++) begin
         add(1, 1, 2'(i), (i % 2 == 1) ? 4'd1 : 4'd0, 4'b0000, 0, 0, 1);
         add(1, 0, 0, 0, 4'(1 << i), 1, 1, Q);
         add(1, 0, 0, 0, 4'b0000, 1, 0, Q);
      end
      add(1, 0, 0, 0, 4'b0000, 0, 0, 1);

      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in = '0; len = '0;
      #1;
      chk("reset_state", 4'b0000, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int c = 0; c < 10; c++) begin
         #1;
         chk($sformatf("idle_%0d", c), 4'b0000, 0, 0, 1);
         step();
      end

      foreach (tbl[k]) begin
         enable   = tbl[k].en;
         in_valid = tbl[k].vld;
         in       = tbl[k].in;
         len      = tbl[k].len;
         #1;
         chk($sformatf("vec_%0d", k), tbl[k].eo, tbl[k].eb, tbl[k].ed, tbl[k].er);
         step();
      end

      // Abort a long pulse on its 5th ACTIVE cycle
      in_valid = 1; in = 3; len = 15;
      #1;
      chk("abort_hs", 4'b0000, 0, 0, 1);
      step();
      in_valid = 0;
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) enable = 0;
         #1;
         chk($sformatf("abort_act_%0d", k), 4'b1000, 1, 0, (k == 5) ? 1'b0 : Q);
         step();
      end
      #1;
      chk("abort_idle", 4'b0000, 0, 0, 0);
      step();
      enable = 1; in_valid = 1; in = 1; len = 1;
      #1;
      chk("reenable_hs", 4'b0000, 0, 0, 1);
      step();
      in_valid = 0;
      #1;
      chk("reenable_pulse", 4'b0010, 1, 1, Q);
      step();
      #1;
      chk("reenable_gap", 4'b0000, 1, 0, Q);
      step();
      #1;
      chk("reenable_idle", 4'b0000, 0, 0, 1);

      // Asynchronous reset on the 3rd ACTIVE cycle
      in_valid = 1; in = 1; len = 8;
      step();
      in_valid = 0;
      step();
      step();
      #1;
      chk("rst_pre", 4'b0010, 1, 0, Q);
      #1 rst = 1;
      #1;
      chk("rst_async", 4'b0000, 0, 0, 0);
      #2 rst = 0;
      #1;
      chk("rst_release", 4'b0000, 0, 0, 1);
      step();
      #1;
      chk("rst_idle", 4'b0000, 0, 0, 1);

`ifdef DEC_PULSE_QUEUE_EN
      in_valid = 1; in = 0; len = 2;
      #1;
      chk("q_hs1", 4'b0000, 0, 0, 1);
      step();
      in = 3; len = 1;
      #1;
      chk("q_act1", 4'b0001, 1, 0, 1);
      step();
      in = 2; len = 5;
      #1;
      chk("q_full", 4'b0001, 1, 1, 0);
      step();
      in_valid = 0;
      #1;
      chk("q_gap1", 4'b0000, 1, 0, 0);
      step();
      #1;
      chk("q_act2", 4'b1000, 1, 1, 1);
      step();
      #1;
      chk("q_gap2", 4'b0000, 1, 0, 1);
      step();
      #1;
      chk("q_idle", 4'b0000, 0, 0, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
